// File: rtl/decoder_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// decoder_seq_ctrl_if : control inputs and select-code outputs of the sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface decoder_seq_ctrl_if;
   logic       run_en;
   logic       dir;
   logic       load;
   logic [2:0] load_val;
   logic       in_1;
   logic       in_2;
   logic       in_3;
   logic       tick;
   logic       busy;

   modport master (
      output run_en, dir, load, load_val,
      input  in_1, in_2, in_3, tick, busy
   );

   modport slave (
      input  run_en, dir, load, load_val,
      output in_1, in_2, in_3, tick, busy
   );
endinterface

`default_nettype wire

// File: rtl/decoder_seq_ctrl.sv
// ---------------------------------------------------------------------------
// decoder_seq_ctrl : steps a 3-bit decoder select code once per dwell period.
// Option macro DECODER_SEQ_PINGPONG_EN: bounce at 0/7 instead of wrapping.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module decoder_seq_ctrl #(
   parameter int unsigned      CNT_W   = 24,
   parameter logic [CNT_W-1:0] CNT_MAX = 24'd9_999_999
) (
   input  wire                  sys_clk,
   input  wire                  sys_rst_n,
   decoder_seq_ctrl_if.slave    bus
);

   localparam logic [1:0]       c_idle    = 2'd0;
   localparam logic [1:0]       c_run     = 2'd1;
   localparam logic [1:0]       c_pause   = 2'd2;
   localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       code_q, code_d;
   logic             tick_q, tick_d;
   logic             busy_q, busy_d;
   logic             w_step;
   logic [2:0]       w_next_code;

   // State register
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= c_idle;
         cnt_q   <= '0;
         code_q  <= 3'd0;
         tick_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         tick_q  <= tick_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state logic; IDLE is only re-entered through reset
   always_comb begin
      state_d = state_q;
      case (state_q)
         c_idle:  if (bus.run_en)  state_d = c_run;
         c_run:   if (!bus.run_en) state_d = c_pause;
         c_pause: if (bus.run_en)  state_d = c_run;
         default: state_d = c_idle;
      endcase
   end

   // Output logic: busy is registered alongside the state it reflects
   always_comb begin
      busy_d = (state_d == c_run);
   end

`ifdef DECODER_SEQ_PINGPONG_EN
   logic pp_dir_q, pp_dir_d;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) pp_dir_q <= 1'b0;
      else            pp_dir_q <= pp_dir_d;
   end

   // Direction flag: 0 = up, 1 = down; reverses when a step hits an end code
   always_comb begin
      w_next_code = code_q;
      pp_dir_d    = pp_dir_q;
      if (bus.load) begin
         pp_dir_d = bus.dir;
      end else if (!pp_dir_q) begin
         if (code_q == 3'd7) begin
            w_next_code = 3'd6;
            if (w_step) pp_dir_d = 1'b1;
         end else begin
            w_next_code = code_q + 3'd1;
         end
      end else begin
         if (code_q == 3'd0) begin
            w_next_code = 3'd1;
            if (w_step) pp_dir_d = 1'b0;
         end else begin
            w_next_code = code_q - 3'd1;
         end
      end
   end
`else
   always_comb begin
      w_next_code = bus.dir ? (code_q - 3'd1) : (code_q + 3'd1);
   end
`endif

   // Dwell counter and code update; load overrides a coincident step
   always_comb begin
      w_step = (state_q == c_run) && (cnt_q == CNT_MAX);
      case (state_q)
         c_run:   cnt_d = w_step ? '0 : (cnt_q + c_cnt_one);
         c_pause: cnt_d = cnt_q;
         default: cnt_d = '0;
      endcase
      code_d = code_q;
      tick_d = 1'b0;
      if (bus.load) begin
         cnt_d  = '0;
         code_d = bus.load_val;
      end else if (w_step) begin
         code_d = w_next_code;
         tick_d = 1'b1;
      end
   end

   assign bus.in_1 = code_q[2];
   assign bus.in_2 = code_q[1];
   assign bus.in_3 = code_q[0];
   assign bus.tick = tick_q;
   assign bus.busy = busy_q;

endmodule

`default_nettype wire

// File: doc/decoder_seq_ctrl.md
Name: decoder_seq_ctrl

Overview:
- Upstream driver for the 3-to-8 decoder; produces the 3-bit select code on in_1/in_2/in_3.
- Steps the code up or down once per programmable dwell period, giving a running-light pattern on the decoder's one-hot out[7:0].
- Supports run/pause and a synchronous load of an arbitrary start code.
- One clock domain; all outputs registered.

Parameters:
- CNT_MAX, 24'd9_999_999, dwell terminal count; code steps every CNT_MAX+1 clocks (200 ms at 50 MHz). Benches override to 4.
- CNT_W, 24, dwell counter width; must hold CNT_MAX.

Ports:
- sys_clk  input  1  system clock, rising edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- run_en  input  1  level; 1 = stepping enabled, 0 = pause.
- dir  input  1  0 = count up, 1 = count down.
- load  input  1  one-cycle pulse; load load_val into the code.
- load_val  input  3  code to load.
- in_1  output  1  code bit 2 (MSB); connects to decoder in_1.
- in_2  output  1  code bit 1; connects to decoder in_2.
- in_3  output  1  code bit 0 (LSB); connects to decoder in_3.
- tick  output  1  one-cycle pulse in the cycle a step updates the code.
- busy  output  1  1 while FSM is in RUN.

Behaviour:
- Reset (async assert, sync release): code=3'b000, cnt=0, tick=0, busy=0, state=IDLE.
- Code register: {in_1,in_2,in_3}, driven directly from flops.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE->RUN on run_en=1.
  - RUN->PAUSE on run_en=0.
  - PAUSE->RUN on run_en=1.
  - No path back to IDLE except reset.
- busy=1 exactly when state==RUN (registered, same cycle as state).
- Dwell counter:
  - In RUN: increments each clock; at cnt==CNT_MAX it wraps to 0 and a step occurs.
  - In PAUSE: holds its value; resumes from that value on return to RUN (no restart).
  - In IDLE: held at 0.
- Step:
  - dir=0: code+1, 7 wraps to 0.
  - dir=1: code-1, 0 wraps to 7.
  - dir is sampled in the step cycle only.
  - tick=1 for exactly the clock edge on which the new code appears, 0 otherwise.
  - First step after IDLE->RUN comes CNT_MAX+1 clocks after entering RUN.
- Load (any state):
  - Next edge sets code=load_val and cnt=0; state is unchanged.
  - No tick on load.
  - load has priority over a coincident step; that step is discarded.
- run_en falling in the cycle cnt==CNT_MAX: the FSM evaluates the RUN state, so the step still happens (tick=1); the state is PAUSE on the following edge.
- Reset mid-dwell: all registers return to reset values immediately, regardless of clock.
- Arithmetic: all code math is modulo 8 on 3 bits; no other overflow is possible since cnt never exceeds CNT_MAX.

Optional Feature:
- Macro: DECODER_SEQ_PINGPONG_EN.
- Defined: an internal direction flag replaces wrap-around.
  - Flag loads from dir on reset release (value 0) and on load.
  - Stepping up at code 7 reverses the flag and steps to 6; stepping down at code 0 reverses it and steps to 1.
  - The dir port is ignored except at load.
- Undefined: plain wrap-around per dir as above; no direction flag is synthesized.

Test Plan (CNT_MAX=4):
- Reset then run_en=1, dir=0 -> code 0,1,2,… advancing every 5 clocks; tick pulses coincide with each change; 7->0 wrap observed; busy=1 from the edge after run_en rises.
- dir=1 from code 1 -> sequence 1,0,7,6, each tick aligned with the change.
- run_en=0 after 2 dwell clocks, hold 10 clocks, re-assert -> code frozen, busy=0 during pause; next step 3 clocks after resume.
- load=1, load_val=5 in the cycle cnt==4 -> code=5, no tick, next step 5 clocks later to 6.
- Assert sys_rst_n=0 asynchronously mid-dwell with code=3 -> code=0, tick=0, busy=0 before the next clock edge.
- With DECODER_SEQ_PINGPONG_EN, load 6 with dir=0 -> sequence 6,7,6,5,…,1,0,1; decoder out walks 8'b0100_0000, 8'b1000_0000, 8'b0100_0000, …
